// File: rtl/queue_replay_ctrl_if.sv
// Producer/consumer valid-ready bundle for queue_replay_ctrl.
// slave = controller side, master = producer/consumer side.
interface queue_replay_ctrl_if;
  logic       in_valid;
  logic [1:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/queue_replay_ctrl.sv
// Load/replay sequencer for the 2-bit, 256-entry symbol queue.
// Define QREPLAY_STATS_EN to add the sym_total_o handshake counter.
module queue_replay_ctrl #(
  parameter int PASS_W = 4,
  parameter int CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              play_i,
  input  logic [PASS_W-1:0] num_passes_i,
  queue_replay_ctrl_if.slave s,
  output logic              busy_o,
  output logic              done_o,
  output logic              trunc_o,
  output logic [CNT_W-1:0]  length_o,
  output logic [PASS_W-1:0] pass_cnt_o,
  output logic              q_clear_o,
  output logic              q_enqueue_o,
  output logic              q_dequeue_o,
  output logic              q_rst_front_o,
  output logic [1:0]        q_data_in_o,
  input  logic [1:0]        q_data_out_i,
  input  logic              q_finish_i,
  input  logic              q_full_i
`ifdef QREPLAY_STATS_EN
  ,
  output logic [15:0]       sym_total_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_REWIND,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  length_q;
  logic [CNT_W-1:0]  index_q;
  logic [PASS_W-1:0] pass_cnt_q;
  logic [PASS_W-1:0] passes_q;
  logic              trunc_q;
  logic [1:0]        hold_q;
  logic              fresh_q;

  logic in_hs;
  logic out_hs;
  logic last_sym;
  logic last_pass;

  assign in_hs  = (state_q == S_LOAD) && s.in_valid && !q_full_i;
  assign out_hs = (state_q == S_PRESENT) && s.out_ready;

  assign last_sym  = (index_q + CNT_W'(1)) == length_q;
  assign last_pass = ({1'b0, pass_cnt_q} + (PASS_W+1)'(1))
                     == {1'b0, passes_q};

  assign s.in_ready  = (state_q == S_LOAD) && !q_full_i;
  assign s.out_valid = (state_q == S_PRESENT);
  // queue data_out is only guaranteed the cycle after dequeue
  assign s.out_data  = fresh_q ? q_data_out_i : hold_q;
  assign s.out_last  = (state_q == S_PRESENT) && last_sym && last_pass;

  assign q_clear_o     = rst || (state_q == S_CLEAR);
  assign q_enqueue_o   = in_hs;
  assign q_dequeue_o   = (state_q == S_FETCH) && !q_finish_i;
  assign q_rst_front_o = (state_q == S_REWIND);
  assign q_data_in_o   = s.in_data;

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign trunc_o    = trunc_q;
  assign length_o   = length_q;
  assign pass_cnt_o = pass_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      length_q   <= '0;
      index_q    <= '0;
      pass_cnt_q <= '0;
      passes_q   <= PASS_W'(1);
      trunc_q    <= 1'b0;
      hold_q     <= '0;
      fresh_q    <= 1'b0;
    end else begin
      fresh_q <= (state_q == S_FETCH) && !q_finish_i;
      if (fresh_q) begin
        hold_q <= q_data_out_i;
      end
      unique case (state_q)
        S_IDLE: begin
          if (load_i) begin
            state_q <= S_CLEAR;
          end else if (play_i) begin
            state_q    <= S_REWIND;
            pass_cnt_q <= '0;
            passes_q   <= (num_passes_i == '0) ? PASS_W'(1)
                                               : num_passes_i;
          end
        end
        S_CLEAR: begin
          length_q <= '0;
          trunc_q  <= 1'b0;
          state_q  <= S_LOAD;
        end
        S_LOAD: begin
          if (in_hs) begin
            length_q <= length_q + CNT_W'(1);
            if (s.in_last) begin
              state_q <= S_IDLE;
            end
          end else if (q_full_i) begin
            trunc_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_REWIND: begin
          index_q <= '0;
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (q_finish_i) begin
            pass_cnt_q <= pass_cnt_q + PASS_W'(1);
            state_q    <= last_pass ? S_DONE : S_REWIND;
          end else begin
            state_q <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (s.out_ready) begin
            index_q <= index_q + CNT_W'(1);
            state_q <= S_FETCH;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef QREPLAY_STATS_EN
  logic [15:0] sym_total_q;

  always_ff @(posedge clk) begin
    if (rst || state_q == S_CLEAR) begin
      sym_total_q <= '0;
    end else if (out_hs && sym_total_q != 16'hFFFF) begin
      sym_total_q <= sym_total_q + 16'd1;
    end
  end

  assign sym_total_o = sym_total_q;
`else
  logic unused_hs;
  assign unused_hs = out_hs;
`endif

endmodule

// File: tb/tb_queue_replay_ctrl.sv
// Directed bench for queue_replay_ctrl with a behavioural 256-entry queue.
// Load/replay tables plus hand-written truncation, empty and reset cases.
module tb_queue_replay_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       play;
  logic [3:0] num_passes;
  logic       busy, done, trunc;
  logic [8:0] length;
  logic [3:0] pass_cnt;
  logic       q_clear, q_enqueue, q_dequeue, q_rst_front;
  logic [1:0] q_data_in;
  logic [1:0] q_data_out = 2'd0;
  logic       q_finish, q_full;
`ifdef QREPLAY_STATS_EN
  logic [15:0] sym_total;
`endif

  always #5 clk = ~clk;

  queue_replay_ctrl_if bus ();

  queue_replay_ctrl #(.PASS_W(4), .CNT_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .play_i       (play),
    .num_passes_i (num_passes),
    .s            (bus),
    .busy_o       (busy),
    .done_o       (done),
    .trunc_o      (trunc),
    .length_o     (length),
    .pass_cnt_o   (pass_cnt),
    .q_clear_o    (q_clear),
    .q_enqueue_o  (q_enqueue),
    .q_dequeue_o  (q_dequeue),
    .q_rst_front_o(q_rst_front),
    .q_data_in_o  (q_data_in),
    .q_data_out_i (q_data_out),
    .q_finish_i   (q_finish),
    .q_full_i     (q_full)
`ifdef QREPLAY_STATS_EN
    ,
    .sym_total_o  (sym_total)
`endif
  );

  // behavioural queue
  logic [1:0] qmem [256];
  logic [8:0] qf = 9'd0;
  logic [8:0] qr = 9'd0;

  assign q_finish = (qf == qr);
  assign q_full   = (qr == 9'd256);

  always @(posedge clk) begin
    if (q_clear) begin
      qf <= 9'd0;
      qr <= 9'd0;
    end else if (q_enqueue) begin
      qmem[qr[7:0]] <= q_data_in;
      qr <= qr + 9'd1;
    end else if (q_dequeue) begin
      q_data_out <= qmem[qf[7:0]];
      qf <= qf + 9'd1;
    end else if (q_rst_front) begin
      qf <= 9'd0;
    end
  end

  int errors = 0;
  int checks = 0;
  int viol   = 0;

  always begin
    @(negedge clk);
    #2;
    if (int'(q_enqueue) + int'(q_dequeue) + int'(q_rst_front) > 1)
      viol++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] d;
    logic       l;
    logic [8:0] len;
  } ld_vec_t;

  typedef struct {
    logic [1:0] d;
    logic       l;
  } rp_vec_t;

  ld_vec_t    ld [5];
  rp_vec_t    rp [10];
  logic [1:0] got_d [$];
  logic       got_l [$];
  int         dones;

  task automatic start_load();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #1;
    chk("clear_pulse", 32'(q_clear), 1);
  endtask

  task automatic load_table();
    start_load();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = ld[i].d;
      bus.in_last  = ld[i].l;
      #1;
      chk("enq_strobe", 32'(q_enqueue), 1);
      @(posedge clk);
      #1;
      chk("len_step", 32'(length), 32'(ld[i].len));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    #1;
    chk("load_idle", 32'(busy), 0);
  endtask

  task automatic run_play(input logic [3:0] np, input bit rnd);
    bit         pend = 0;
    logic [1:0] pend_d = 2'd0;
    bit         fin = 0;
    got_d.delete();
    got_l.delete();
    dones = 0;
    @(negedge clk);
    play = 1'b1;
    num_passes = np;
    @(negedge clk);
    play = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (c != 0) @(negedge clk);
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.out_valid) begin
        if (pend) chk("hold_stable", 32'(bus.out_data), 32'(pend_d));
        if (bus.out_ready) begin
          got_d.push_back(bus.out_data);
          got_l.push_back(bus.out_last);
          pend = 0;
        end else begin
          pend = 1;
          pend_d = bus.out_data;
        end
      end
      if (done) dones++;
      if (!busy) fin = 1;
    end
    if (!fin) chk("play_timeout", 0, 1);
    bus.out_ready = 1'b1;
  endtask

  task automatic check_replay(input string tag);
    chk({tag, "_count"}, 32'(got_d.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < got_d.size()) begin
        chk({tag, "_data"}, 32'(got_d[i]), 32'(rp[i].d));
        chk({tag, "_last"}, 32'(got_l[i]), 32'(rp[i].l));
      end
    end
    chk({tag, "_done"}, 32'(dones), 1);
    chk({tag, "_passes"}, 32'(pass_cnt), 2);
  endtask

  initial begin
    logic [1:0] syms [5];
    int acc;
    bit hit;
    syms = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
    for (int i = 0; i < 5; i++) begin
      ld[i] = '{d: syms[i], l: (i == 4), len: 9'(i + 1)};
    end
    for (int i = 0; i < 10; i++) begin
      rp[i] = '{d: syms[i % 5], l: (i == 9)};
    end

    rst = 1'b1;
    load = 1'b0;
    play = 1'b0;
    num_passes = 4'd0;
    bus.in_valid = 1'b0;
    bus.in_data = 2'd0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_trunc", 32'(trunc), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_strobes",
        32'({q_enqueue, q_dequeue, q_rst_front}), 0);
    chk("rst_length", 32'(length), 0);
    chk("rst_pass_cnt", 32'(pass_cnt), 0);
    chk("rst_q_clear", 32'(q_clear), 1);
    rst = 1'b0;
    #1;
    chk("q_clear_release", 32'(q_clear), 0);

    load_table();
    chk("load_len", 32'(length), 5);

    run_play(4'd2, 1'b0);
    check_replay("rp_ready");
`ifdef QREPLAY_STATS_EN
    chk("sym_total_a", 32'(sym_total), 10);
`endif

    run_play(4'd2, 1'b1);
    check_replay("rp_random");
`ifdef QREPLAY_STATS_EN
    chk("sym_total_b", 32'(sym_total), 20);
`endif

    start_load();
    acc = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 2'(i);
      bus.in_last  = 1'b0;
      #1;
      if (bus.in_ready) acc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("trunc_accepted", 32'(acc), 256);
    chk("trunc_flag", 32'(trunc), 1);
    chk("trunc_length", 32'(length), 256);
    chk("trunc_in_ready", 32'(bus.in_ready), 0);
    chk("trunc_idle", 32'(busy), 0);

    start_load();
    @(negedge clk);
    #1;
    chk("reload_trunc_clr", 32'(trunc), 0);
    chk("reload_len_clr", 32'(length), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_play(4'd0, 1'b0);
    chk("empty_no_out", 32'(got_d.size()), 0);
    chk("empty_pass_cnt", 32'(pass_cnt), 1);
    chk("empty_done", 32'(dones), 1);

    load_table();
    @(negedge clk);
    play = 1'b1;
    num_passes = 4'd3;
    @(negedge clk);
    play = 1'b0;
    acc = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus.out_valid) begin
        if (acc == 3) begin
          rst = 1'b1;
          @(posedge clk);
          #1;
          chk("mid_rst_busy", 32'(busy), 0);
          chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
          chk("mid_rst_q_clear", 32'(q_clear), 1);
          chk("mid_rst_length", 32'(length), 0);
          @(negedge clk);
          rst = 1'b0;
          hit = 1;
        end else begin
          acc++;
        end
      end
    end
    if (!hit) chk("mid_rst_timeout", 0, 1);
    @(negedge clk);
    #1;
    chk("post_rst_finish", 32'(q_finish), 1);

    chk("strobe_onehot", 32'(viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
